// File: rtl/hello_pkg.sv
// Shared definitions for the hello switch-to-LED mirror.
// Holds the board LED width and the matching LED vector type.
package hello_pkg;

    localparam int LED_W = 4;

    typedef logic [LED_W-1:0] led_t;

endpackage

// File: rtl/hello_hb_div.sv
// Heartbeat divider: free-running wrap-around counter, MSB as blink.
// Ports: clk (rising edge), rst (sync, active-high), tick_o (counter MSB).
module hello_hb_div #(
    parameter int DIV_W = 22
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // MSB period is 2^DIV_W clocks, half high and half low.
    assign tick_o = r_cnt[DIV_W-1];

endmodule

// File: rtl/hello.sv
// Registered switch-to-LED mirror with optional heartbeat and polarity.
// Ports: clk, rst (sync, active-high), sw[WIDTH] in, led[WIDTH] out.
module hello
    import hello_pkg::*;
#(
    parameter int WIDTH    = LED_W,
    parameter int LED_INV  = 0,
    parameter int HB_EN    = 0,
    parameter int HB_DIV_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] led
);

    localparam logic [WIDTH-1:0] INV_MASK =
        (LED_INV != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    if (WIDTH < 1) begin : g_bad_width
        $error("hello: WIDTH must be at least 1");
    end

    if ((HB_EN != 0) && (HB_DIV_W < 1)) begin : g_bad_div
        $error("hello: HB_DIV_W must be at least 1 when HB_EN=1");
    end

    logic [WIDTH-1:0] r_led;
    logic [WIDTH-1:0] w_led;

    // Single sampling register; sw is quasi-static so no synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= sw;
        end
    end

    if (HB_EN != 0) begin : g_hb
        logic w_tick;

        hello_hb_div #(
            .DIV_W (HB_DIV_W)
        ) u_hb (
            .clk    (clk),
            .rst    (rst),
            .tick_o (w_tick)
        );

        // Blink the top LED only while every switch reads off.
        always_comb begin
            w_led = r_led;
            if (r_led == '0) begin
                w_led[WIDTH-1] = w_tick;
            end
        end
    end else begin : g_no_hb
        assign w_led = r_led;
    end

    assign led = w_led ^ INV_MASK;

endmodule

// File: tb/tb_hello.sv
// Directed bench for hello: default, inverted and heartbeat variants.
// Table-driven vectors plus hand sequences for reset and heartbeat.
module tb_hello;
    import hello_pkg::*;

    logic clk;
    logic rst;
    led_t sw;
    led_t led_def;
    led_t led_inv;
    led_t led_hb;

    int total;
    int bad;

    hello u_def (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .led (led_def)
    );

    hello #(
        .LED_INV (1)
    ) u_inv (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .led (led_inv)
    );

    hello #(
        .HB_EN    (1),
        .HB_DIV_W (3)
    ) u_hb (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .led (led_hb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        led_t sw;
        led_t exp_def;
        led_t exp_inv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input led_t act, input led_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input led_t s,
                                input led_t ed, input led_t ei);
        vec_t v;
        v.rst = r;
        v.sw = s;
        v.exp_def = ed;
        v.exp_inv = ei;
        return v;
    endfunction

    logic [15:0] hb_pat;

    initial begin
        total = 0;
        bad = 0;

        // Walk 0000..1111, then reset mid-run, then the polarity vector.
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b1110));
        vecs.push_back(mk(0, 4'b0010, 4'b0010, 4'b1101));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 4'b1100));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b1011));
        vecs.push_back(mk(0, 4'b0101, 4'b0101, 4'b1010));
        vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b1001));
        vecs.push_back(mk(0, 4'b0111, 4'b0111, 4'b1000));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 4'b0111));
        vecs.push_back(mk(0, 4'b1001, 4'b1001, 4'b0110));
        vecs.push_back(mk(0, 4'b1010, 4'b1010, 4'b0101));
        vecs.push_back(mk(0, 4'b1011, 4'b1011, 4'b0100));
        vecs.push_back(mk(0, 4'b1100, 4'b1100, 4'b0011));
        vecs.push_back(mk(0, 4'b1101, 4'b1101, 4'b0010));
        vecs.push_back(mk(0, 4'b1110, 4'b1110, 4'b0001));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000));
        vecs.push_back(mk(0, 4'b1010, 4'b1010, 4'b0101));
        vecs.push_back(mk(0, 4'b1010, 4'b1010, 4'b0101));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 4'b1111));
        vecs.push_back(mk(0, 4'b1010, 4'b1010, 4'b0101));
        vecs.push_back(mk(0, 4'b0110, 4'b0110, 4'b1001));

        // Reset for one edge, then release with sw=0.
        rst = 1'b1;
        sw = 4'b0000;
        step();
        chk("reset_def", led_def, 4'b0000);
        chk("reset_inv", led_inv, 4'b1111);
        chk("reset_hb", led_hb, 4'b0000);

        rst = 1'b0;
        step();
        chk("idle_def", led_def, 4'b0000);

        // Output must not follow sw until the next edge.
        sw = 4'b0001;
        #1;
        chk("pre_edge_def", led_def, 4'b0000);
        chk("pre_edge_inv", led_inv, 4'b1111);
        step();
        chk("post_edge_def", led_def, 4'b0001);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            sw = vecs[i].sw;
            step();
            chk($sformatf("vec%0d_def", i), led_def, vecs[i].exp_def);
            chk($sformatf("vec%0d_inv", i), led_inv, vecs[i].exp_inv);
            if (vecs[i].exp_def != 4'b0000) begin
                chk($sformatf("vec%0d_hb", i), led_hb, vecs[i].exp_def);
            end
        end

        // Heartbeat: counter restarts at reset; top bit high for cnt 4..7.
        rst = 1'b1;
        sw = 4'b0000;
        step();
        chk("hb_reset", led_hb, 4'b0000);
        rst = 1'b0;
        hb_pat = 16'b0111_1000_0111_1000;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("hb_blink%0d", k), led_hb,
                {hb_pat[k], 3'b000});
        end

        // Any switch set: plain mirror, no more toggling.
        sw = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("hb_stop%0d", k), led_hb, 4'b0100);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
